// File: rtl/cam_manager.sv
// cam_manager
//   Command-level initiator that owns the CAM read/write/search port. Accepts
//   LOOKUP / INSERT / DELETE / READ commands, sequences the CAM accesses,
//   tracks slot occupancy in a bitmap and returns one response per command.
//
// Optional feature macro: CAM_MANAGER_INIT_SWEEP_EN
//   Defined   : after reset an INIT state writes DELETE_KEY to every index,
//               one per cycle, before the block becomes ready.
//   Undefined : the block is ready (IDLE) straight out of reset.
//
// Ports
//   clk, reset             : clock, synchronous active-high reset
//   cmd_*                  : command channel (valid/ready)
//   resp_*                 : response channel (valid/ready)
//   count_o                : occupied-slot count
//   cam_*                  : CAM strobes, indices, data and results
//   dbg_state_o            : current FSM state (debug / checker binding)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The sender holds valid and its payload stable until that edge;
// the receiver may raise or lower ready freely.
module cam_manager #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] DELETE_KEY = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [DATA_WIDTH-1:0] cmd_key_i,
  input  logic [ADDR_WIDTH-1:0] cmd_index_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [1:0]            resp_status_o,
  output logic [ADDR_WIDTH-1:0] resp_index_o,
  output logic [DATA_WIDTH-1:0] resp_data_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  cam_read_o,
  output logic                  cam_write_o,
  output logic                  cam_search_o,
  output logic [ADDR_WIDTH-1:0] cam_read_index_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [DATA_WIDTH-1:0] cam_write_data_o,
  output logic [DATA_WIDTH-1:0] cam_search_data_o,
  input  logic                  cam_read_valid_i,
  input  logic                  cam_search_valid_i,
  input  logic [DATA_WIDTH-1:0] cam_read_value_i,
  input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
  output logic [2:0]            dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEARCH = 3'd1;
  localparam logic [2:0] S_WAIT_S = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_READ   = 3'd4;
  localparam logic [2:0] S_WAIT_R = 3'd5;
  localparam logic [2:0] S_RESP   = 3'd6;
`ifdef CAM_MANAGER_INIT_SWEEP_EN
  localparam logic [2:0] S_INIT   = 3'd7;
  localparam logic [2:0] LP_RESET_STATE = S_INIT;
  localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(DEPTH - 1);
`else
  localparam logic [2:0] LP_RESET_STATE = S_IDLE;
`endif

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;
  localparam logic [1:0] OP_READ   = 2'd3;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_NOTFOUND = 2'd1;
  localparam logic [1:0] ST_EXISTS   = 2'd2;
  localparam logic [1:0] ST_REJECT   = 2'd3;

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  logic [2:0]            r_state;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_key;
  logic [ADDR_WIDTH-1:0] r_index;
  logic [ADDR_WIDTH-1:0] r_wr_index;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_set;     // 1: pending write allocates, 0: frees
  logic [DEPTH-1:0]      r_bitmap;
  logic [ADDR_WIDTH:0]   r_count;
  logic [1:0]            r_resp_status;
  logic [ADDR_WIDTH-1:0] r_resp_index;
  logic [DATA_WIDTH-1:0] r_resp_data;
`ifdef CAM_MANAGER_INIT_SWEEP_EN
  logic [ADDR_WIDTH-1:0] r_sweep_idx;
`endif

  logic [ADDR_WIDTH-1:0] w_free_index;
  logic                  w_search_hit;
  logic                  w_read_hit;
  logic                  w_sweep;
  logic                  w_wr;

  // Lowest clear bitmap bit; only consulted when the table is not full.
  always_comb begin
    w_free_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_bitmap[i]) w_free_index = i[ADDR_WIDTH-1:0];
    end
  end

  // The bitmap masks CAM hits on slots that hold stale, never-freed data.
  assign w_search_hit = cam_search_valid_i & r_bitmap[cam_search_index_i];
  assign w_read_hit   = cam_read_valid_i & r_bitmap[r_index];

`ifdef CAM_MANAGER_INIT_SWEEP_EN
  // Gated by reset so no write strobe appears while reset is held in INIT.
  assign w_sweep = (r_state == S_INIT) & ~reset;
`else
  assign w_sweep = 1'b0;
`endif
  assign w_wr = (r_state == S_WRITE);

  assign cmd_ready_o       = (r_state == S_IDLE);
  assign resp_valid_o      = (r_state == S_RESP);
  assign resp_status_o     = r_resp_status;
  assign resp_index_o      = r_resp_index;
  assign resp_data_o       = r_resp_data;
  assign count_o           = r_count;
  assign dbg_state_o       = r_state;

  assign cam_search_o      = (r_state == S_SEARCH);
  assign cam_search_data_o = cam_search_o ? r_key : '0;
  assign cam_read_o        = (r_state == S_READ);
  assign cam_read_index_o  = cam_read_o ? r_index : '0;
  assign cam_write_o       = w_wr | w_sweep;
`ifdef CAM_MANAGER_INIT_SWEEP_EN
  assign cam_write_index_o = w_wr ? r_wr_index : (w_sweep ? r_sweep_idx : '0);
  assign cam_write_data_o  = w_wr ? r_wr_data : (w_sweep ? DELETE_KEY : '0);
`else
  assign cam_write_index_o = w_wr ? r_wr_index : '0;
  assign cam_write_data_o  = w_wr ? r_wr_data : '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= LP_RESET_STATE;
      r_op          <= OP_LOOKUP;
      r_key         <= '0;
      r_index       <= '0;
      r_wr_index    <= '0;
      r_wr_data     <= '0;
      r_wr_set      <= 1'b0;
      r_bitmap      <= '0;
      r_count       <= '0;
      r_resp_status <= ST_OK;
      r_resp_index  <= '0;
      r_resp_data   <= '0;
`ifdef CAM_MANAGER_INIT_SWEEP_EN
      r_sweep_idx   <= '0;
`endif
    end else begin
      case (r_state)
`ifdef CAM_MANAGER_INIT_SWEEP_EN
        S_INIT: begin
          r_sweep_idx <= r_sweep_idx + 1'b1;
          if (r_sweep_idx == LP_LAST) r_state <= S_IDLE;
        end
`endif
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_op    <= cmd_op_i;
            r_key   <= cmd_key_i;
            r_index <= cmd_index_i;
            if (cmd_op_i == OP_READ) begin
              r_state <= S_READ;
            end else if (cmd_key_i == DELETE_KEY) begin
              // Reserved key: answer immediately without touching the CAM.
              r_resp_status <= ST_REJECT;
              r_resp_index  <= '0;
              r_resp_data   <= '0;
              r_state       <= S_RESP;
            end else begin
              r_state <= S_SEARCH;
            end
          end
        end
        S_SEARCH: r_state <= S_WAIT_S;
        S_WAIT_S: begin
          r_resp_data  <= '0;
          r_resp_index <= '0;
          r_state      <= S_RESP;
          case (r_op)
            OP_LOOKUP: begin
              r_resp_status <= w_search_hit ? ST_OK : ST_NOTFOUND;
              if (w_search_hit) r_resp_index <= cam_search_index_i;
            end
            OP_INSERT: begin
              if (w_search_hit) begin
                r_resp_status <= ST_EXISTS;
                r_resp_index  <= cam_search_index_i;
              end else if (r_count == LP_DEPTH) begin
                r_resp_status <= ST_REJECT;
              end else begin
                r_wr_index    <= w_free_index;
                r_wr_data     <= r_key;
                r_wr_set      <= 1'b1;
                r_resp_status <= ST_OK;
                r_resp_index  <= w_free_index;
                r_state       <= S_WRITE;
              end
            end
            OP_DELETE: begin
              if (w_search_hit) begin
                r_wr_index    <= cam_search_index_i;
                r_wr_data     <= DELETE_KEY;
                r_wr_set      <= 1'b0;
                r_resp_status <= ST_OK;
                r_resp_index  <= cam_search_index_i;
                r_state       <= S_WRITE;
              end else begin
                r_resp_status <= ST_NOTFOUND;
              end
            end
            default: r_resp_status <= ST_REJECT;
          endcase
        end
        S_WRITE: begin
          // Occupancy changes on the same edge the CAM write completes.
          r_bitmap[r_wr_index] <= r_wr_set;
          r_count <= r_wr_set ? r_count + 1'b1 : r_count - 1'b1;
          r_state <= S_RESP;
        end
        S_READ: r_state <= S_WAIT_R;
        S_WAIT_R: begin
          r_resp_status <= w_read_hit ? ST_OK : ST_NOTFOUND;
          r_resp_index  <= r_index;
          r_resp_data   <= w_read_hit ? cam_read_value_i : '0;
          r_state       <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= LP_RESET_STATE;
      endcase
    end
  end

endmodule

// File: doc/cam_manager.md
# cam_manager

Command-level initiator that owns the CAM's read/write/search port. Accepts LOOKUP, INSERT, DELETE and READ commands over a valid/ready interface, sequences the required CAM accesses, tracks slot occupancy in a bitmap, and returns one response per command. Sits between the host logic and the CAM; no other agent drives the CAM port.

## Interface
- DATA_WIDTH, 32, key width; matches the CAM data width
- ADDR_WIDTH, 5, index width
- DEPTH, 1<<ADDR_WIDTH, number of CAM entries
- DELETE_KEY, 0, reserved tombstone key; never a legal user key
- clk  in  1  clock; everything is on the rising edge
- reset  in  1  synchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_op_i  in  2  0 LOOKUP, 1 INSERT, 2 DELETE, 3 READ
- cmd_key_i  in  DATA_WIDTH  key for LOOKUP/INSERT/DELETE
- cmd_index_i  in  ADDR_WIDTH  index for READ
- resp_valid_o  out  1  response valid, held until resp_ready_i
- resp_ready_i  in  1  response accepted
- resp_status_o  out  2  0 OK, 1 NOTFOUND, 2 EXISTS, 3 REJECT
- resp_index_o  out  ADDR_WIDTH  matched, allocated or read index
- resp_data_o  out  DATA_WIDTH  READ value; 0 for the other ops
- count_o  out  ADDR_WIDTH+1  occupied-slot count
- cam_read_o, cam_write_o, cam_search_o  out  1 each  single-cycle CAM strobes
- cam_read_index_o, cam_write_index_o  out  ADDR_WIDTH  CAM indices
- cam_write_data_o, cam_search_data_o  out  DATA_WIDTH  CAM data
- cam_read_valid_i, cam_search_valid_i  in  1  CAM result flags
- cam_read_value_i  in  DATA_WIDTH  CAM read data
- cam_search_index_i  in  ADDR_WIDTH  lowest matching CAM index

## Operation
- CAM contract: search and read results appear exactly one cycle after the strobe; a write is complete at the strobe edge.
- States: INIT, IDLE, SEARCH, WAIT_S, WRITE, READ, WAIT_R, RESP.
- IDLE: cmd_ready_o=1 only here. Key == DELETE_KEY on LOOKUP/INSERT/DELETE -> RESP with REJECT, no CAM access. READ -> READ. Otherwise -> SEARCH.
- SEARCH: cam_search_o=1, cam_search_data_o=key. WAIT_S samples the result. Hit = cam_search_valid_i & bitmap[cam_search_index_i].
- LOOKUP: hit -> OK, index; miss -> NOTFOUND.
- INSERT: hit -> EXISTS, index; miss and count_o==DEPTH -> REJECT; else WRITE key at the lowest clear bitmap index, set the bit, increment count, OK, index.
- DELETE: hit -> WRITE DELETE_KEY at index, clear the bit, decrement count, OK, index; miss -> NOTFOUND.
- READ: cam_read_o=1; WAIT_R samples. OK with value if cam_read_valid_i & bitmap[index], else NOTFOUND with data 0.
- RESP: outputs stable while resp_valid_o=1 and resp_ready_i=0; on handshake -> IDLE.
- One command in flight; commands are never overlapped or reordered.
- Unused CAM outputs are 0 whenever their strobe is low.

## Timing
- Reset values: cmd_ready_o 0 with INIT sweep, else 1; resp_valid_o 0; resp_status_o, resp_index_o, resp_data_o 0; count_o 0; all cam_* strobes 0; bitmap cleared.
- LOOKUP, DELETE-miss and INSERT-exists: accept at cycle 0, search strobe at 1, sample at 2, resp_valid_o at 3.
- INSERT-new and DELETE-hit: write strobe at 3, resp_valid_o at 4; bitmap and count update at the write edge.
- READ: read strobe at 1, resp_valid_o at 3. REJECT on the reserved key: resp_valid_o at 1.
- resp_ready_i high when resp_valid_o rises: transfer that cycle, cmd_ready_o=1 next cycle.
- Reset asserted in any state: a synchronous return to the reset state; any in-flight response is discarded, and strobes drop in the same edge.

## Configuration
- CAM_MANAGER_INIT_SWEEP_EN defined: after reset, INIT writes DELETE_KEY to indices 0..DEPTH-1, one per cycle. cmd_ready_o stays 0 for DEPTH cycles, then the block enters IDLE.
- Undefined: no INIT state; IDLE directly after reset. The integrator guarantees that CAM contents never match a live key; the bitmap check still masks stale hits.

## Test plan
- Reset, sweep enabled -> DEPTH write strobes with data 0 at indices 0..31, then cmd_ready_o=1 and count_o=0.
- INSERT 0xA5A5_0001, then INSERT 0xA5A5_0002 -> OK at index 0, then OK at index 1; count_o=2; second INSERT 0xA5A5_0001 -> EXISTS at index 0.
- LOOKUP 0xA5A5_0002 -> OK at index 1 on cycle 3; LOOKUP 0xDEAD_BEEF -> NOTFOUND.
- DELETE 0xA5A5_0001 -> OK, write of 0 at index 0, count_o=1; then INSERT 0x1234 -> OK at index 0 (reuse); READ index 0 -> OK with data 0x1234.
- Fill all 32 slots, then INSERT a new key -> REJECT; INSERT key 0 -> REJECT on cycle 1 with no CAM strobe.
- Hold resp_ready_i low for 5 cycles -> response stable and cmd_ready_o=0; reset asserted during WAIT_S -> resp_valid_o=0, count_o=0, next cycle enters INIT.
